// File: rtl/board_input_cond.sv
// Board input conditioning: synchronizes and debounces the reset button, fetch-enable
// switch and GPIO switches, and sequences a stretched SoC reset request.
module board_input_cond #(
    parameter int GpioCount       = 4,
    parameter int DebounceCycles  = 20000,
    parameter int ResetHoldCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 btn_rst_i,
    input  logic                 sw_fetch_en_i,
    input  logic [GpioCount-1:0] sw_gpio_i,
    output logic                 sys_reset_o,
    output logic                 fetch_en_o,
    output logic [GpioCount-1:0] gpio_o,
    output logic [GpioCount-1:0] gpio_chg_o
);

    localparam int NumIn = GpioCount + 2;
    localparam int DbW   = $clog2(DebounceCycles + 1);
    localparam int HoldW = $clog2(ResetHoldCycles + 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(ResetHoldCycles - 1);

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        PRESSED
    } state_t;

    logic [NumIn-1:0] raw;
    logic [NumIn-1:0] sync_p0;
    logic [NumIn-1:0] sync_p1;
    logic [NumIn-1:0] stable;
    logic [DbW-1:0]   db_cnt [NumIn];

    logic [GpioCount-1:0] gpio_d;

    state_t           state;
    state_t           state_next;
    logic [HoldW-1:0] hold_cnt;
    logic [HoldW-1:0] hold_cnt_next;
    logic             btn_db;
    logic             fetch_db;

    // Bit 0 is the button, bit 1 the fetch switch, the rest the GPIO switches.
    assign raw = {sw_gpio_i, sw_fetch_en_i, btn_rst_i};

    // Stage p0/p1: two-flop synchronizers; then per-input debounce on the p1 value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            stable  <= '0;
            for (int i = 0; i < NumIn; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < NumIn; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DbLast) begin
                    stable[i] <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DbW'(1);
                end
            end
        end
    end

    assign btn_db   = stable[0];
    assign fetch_db = stable[1];
    assign gpio_o   = stable[NumIn-1:2];

    // Change pulse lands one cycle after the debounced level moves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_d     <= '0;
            gpio_chg_o <= '0;
        end else begin
            gpio_d     <= gpio_o;
            gpio_chg_o <= gpio_o ^ gpio_d;
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            HOLD: begin
                if (btn_db) begin
                    state_next    = PRESSED;
                    hold_cnt_next = '0;
                end else if (hold_cnt == HoldLast) begin
                    state_next    = RUN;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HoldW'(1);
                end
            end
            RUN: begin
                if (btn_db) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!btn_db) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = HOLD;
                hold_cnt_next = '0;
            end
        endcase
    end

    // sys_reset_o is registered from the next state so it never glitches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            sys_reset_o <= 1'b1;
            fetch_en_o  <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            sys_reset_o <= (state_next != RUN);
            fetch_en_o  <= fetch_db & ~sys_reset_o;
        end
    end

endmodule

// File: tb/tb_board_input_cond.sv
// Self-checking bench for board_input_cond: window-based reference model compared every
// cycle, plus directed scenarios with hand-computed latencies.
module tb_board_input_cond;

    localparam int G   = 4;
    localparam int DC  = 4;
    localparam int RHC = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn = 1'b0;
    logic         fetch_sw = 1'b0;
    logic [G-1:0] gpio_sw = '0;

    logic         sys_reset;
    logic         fetch_en;
    logic [G-1:0] gpio;
    logic [G-1:0] gpio_chg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    board_input_cond #(
        .GpioCount      (G),
        .DebounceCycles (DC),
        .ResetHoldCycles(RHC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_rst_i    (btn),
        .sw_fetch_en_i(fetch_sw),
        .sw_gpio_i    (gpio_sw),
        .sys_reset_o  (sys_reset),
        .fetch_en_o   (fetch_en),
        .gpio_o       (gpio),
        .gpio_chg_o   (gpio_chg)
    );

    // Reference model. An input's accepted level flips once its synchronized value has
    // disagreed with it on DC consecutive clock edges. The reset request is high while the
    // debounced button is held, and for RHC edges after power-on or after a release.
    logic [G+1:0] m_s0, m_s1, m_stable;
    logic [G+1:0] m_hist [DC-1];
    int           m_hold;
    logic         m_pressed, m_sysrst, m_fetch;
    logic [G-1:0] m_gpio_d, m_chg;
    wire  [G-1:0] m_gpio = m_stable[G+1:2];

    always @(posedge clk or negedge rst_n) begin
        logic [G+1:0] nxt;
        logic         all_diff;
        if (!rst_n) begin
            m_s0 = '0;
            m_s1 = '0;
            m_stable = '0;
            for (int k = 0; k < DC - 1; k++) m_hist[k] = '0;
            m_hold = 0;
            m_pressed = 1'b0;
            m_sysrst = 1'b1;
            m_fetch = 1'b0;
            m_gpio_d = '0;
            m_chg = '0;
        end else begin
            nxt = m_stable;
            for (int i = 0; i < G + 2; i++) begin
                all_diff = (m_s1[i] != m_stable[i]);
                for (int k = 0; k < DC - 1; k++)
                    if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) nxt[i] = m_s1[i];
            end
            for (int k = DC - 2; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s1;
            m_fetch  = m_stable[1] & ~m_sysrst;
            m_chg    = m_gpio_d ^ m_stable[G+1:2];
            m_gpio_d = m_stable[G+1:2];
            if (m_stable[0]) begin
                m_pressed = 1'b1;
                m_sysrst  = 1'b1;
            end else if (m_pressed) begin
                m_pressed = 1'b0;
                m_hold    = 0;
                m_sysrst  = 1'b1;
            end else if (m_hold < RHC) begin
                m_hold++;
                m_sysrst = (m_hold < RHC);
            end
            m_s1 = m_s0;
            m_s0 = {gpio_sw, fetch_sw, btn};
            m_stable = nxt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: compare at the falling edge, then leave the caller 1 time unit
    // later to drive the next inputs.
    task automatic tick();
        @(negedge clk);
        check("model_sys_reset", {31'd0, sys_reset}, {31'd0, m_sysrst});
        check("model_fetch_en", {31'd0, fetch_en}, {31'd0, m_fetch});
        check("model_gpio", {28'd0, gpio}, {28'd0, m_gpio});
        check("model_gpio_chg", {28'd0, gpio_chg}, {28'd0, m_chg});
        #1;
    endtask

    task automatic wait_sys(input logic val, output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (sys_reset === val) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_gpio(input logic [G-1:0] val, output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (gpio === val) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sys_reset"}, {31'd0, sys_reset}, 32'd1);
        check({tag, "_fetch_en"}, {31'd0, fetch_en}, 32'd0);
        check({tag, "_gpio"}, {28'd0, gpio}, 32'd0);
        check({tag, "_gpio_chg"}, {28'd0, gpio_chg}, 32'd0);
    endtask

    initial begin
        int   n;
        logic ok;

        // Held in reset, then power-up hold with all inputs low.
        repeat (3) tick();
        check_reset_values("in_reset");
        rst_n = 1'b1;
        wait_sys(1'b0, n);
        check("powerup_hold_edges", n, 32'd8);
        repeat (4) tick();
        check("fetch_off_idle", {31'd0, fetch_en}, 32'd0);

        // Clean GPIO change: six edges to the level, then a single change pulse.
        gpio_sw = 4'b0101;
        wait_gpio(4'b0101, n);
        check("gpio_latency", n, 32'd6);
        tick();
        check("gpio_chg_pulse", {28'd0, gpio_chg}, 32'h5);
        tick();
        check("gpio_chg_clear", {28'd0, gpio_chg}, 32'h0);
        gpio_sw = 4'b0000;
        repeat (10) tick();

        // Three-cycle glitch is rejected.
        gpio_sw[0] = 1'b1;
        repeat (3) tick();
        gpio_sw[0] = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            tick();
            if (gpio !== 4'b0000 || gpio_chg !== 4'b0000) ok = 1'b0;
        end
        check("glitch_rejected", {31'd0, ok}, 32'd1);

        // Button press in RUN: reset rises after 7 edges, release adds debounce + full hold.
        btn = 1'b1;
        wait_sys(1'b1, n);
        check("btn_press_edges", n, 32'd7);
        ok = 1'b1;
        repeat (13) begin
            tick();
            if (sys_reset !== 1'b1 || fetch_en !== 1'b0) ok = 1'b0;
        end
        check("btn_held_reset", {31'd0, ok}, 32'd1);
        btn = 1'b0;
        wait_sys(1'b0, n);
        check("btn_release_edges", n, 32'd15);

        // Fetch switch on at power-up: enable rises once, one edge after the hold ends.
        rst_n = 1'b0;
        fetch_sw = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_sys(1'b0, n);
        check("fetch_hold_edges", n, 32'd8);
        check("fetch_first_run", {31'd0, fetch_en}, 32'd0);
        tick();
        check("fetch_rise", {31'd0, fetch_en}, 32'd1);

        // Button already down while the hold runs: hold is abandoned and restarts on release.
        rst_n = 1'b0;
        btn = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("btn_in_hold_pressed", {31'd0, sys_reset}, 32'd1);
        btn = 1'b0;
        wait_sys(1'b0, n);
        check("btn_in_hold_release_edges", n, 32'd15);
        tick();
        check("fetch_after_rehold", {31'd0, fetch_en}, 32'd1);

        // Asynchronous reset mid-debounce and mid-hold.
        gpio_sw = 4'b1111;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_debounce_rst");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_hold_rst");
        tick();
        rst_n = 1'b1;
        wait_sys(1'b0, n);
        check("rehold_after_rst_edges", n, 32'd8);

        // Randomized inputs with occasional reset pulses.
        repeat (3000) begin
            tick();
            for (int i = 0; i < G; i++)
                if ($urandom_range(0, 5) == 0) gpio_sw[i] = ~gpio_sw[i];
            if ($urandom_range(0, 29) == 0) fetch_sw = ~fetch_sw;
            if ($urandom_range(0, 39) == 0) btn = ~btn;
            rst_n = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
